// File: rtl/tank_motion.sv
// tank_motion: per-frame motion stage for one tank.
//   Owns the heading index (AngleI -> sin/cos lookup), integrates a 10.4
//   fixed-point X/Y position from the returned magnitudes, and checks each
//   candidate position with the wall checker over a req/ack handshake.
// Ports:
//   Clk, Reset               clock, synchronous active-high reset
//   frame_tick               one-cycle pulse per video frame
//   rot_left/rot_right       rotate keys; fwd/back drive keys
//   sin, cos                 unsigned magnitudes (16 = 1.0) for AngleI
//   AngleI                   heading index 0..44 (8 degrees per step)
//   PosX, PosY               registered integer pixel position
//   wall_req/wall_x/wall_y   candidate request to the wall checker
//   wall_ack/wall_hit        checker result (hit valid with ack)
//   busy                     high whenever the FSM is not idle
// Optional feature: define TANK_MOTION_SLIDE_EN to retry a blocked move as
//   X-only, then Y-only, so the tank slides along walls.
module tank_motion #(
  parameter int INIT_X      = 320,
  parameter int INIT_Y      = 240,
  parameter int INIT_ANGLE  = 0,
  parameter int ROT_DIV     = 2,
  parameter int SPEED_SHIFT = 0,
  parameter int X_MAX       = 639,
  parameter int Y_MAX       = 479
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_tick,
  input  logic       rot_left,
  input  logic       rot_right,
  input  logic       fwd,
  input  logic       back,
  input  logic [7:0] sin,
  input  logic [7:0] cos,
  output logic [5:0] AngleI,
  output logic [9:0] PosX,
  output logic [9:0] PosY,
  output logic       wall_req,
  output logic [9:0] wall_x,
  output logic [9:0] wall_y,
  input  logic       wall_ack,
  input  logic       wall_hit,
  output logic       busy
);

  localparam int              RW        = (ROT_DIV > 1) ? $clog2(ROT_DIV) : 1;
  localparam logic [RW-1:0]   ROT_LAST  = RW'(ROT_DIV - 1);
  localparam logic [13:0]     X_MAX_FP  = 14'(X_MAX << 4);
  localparam logic [13:0]     Y_MAX_FP  = 14'(Y_MAX << 4);
  localparam logic [5:0]      ANGLE_TOP = 6'd44;

  typedef enum logic [2:0] {S_IDLE, S_ROT, S_CALC, S_REQ, S_COMMIT} state_t;

  state_t          state_q, state_d;
  logic [13:0]     x_q, x_d, y_q, y_d;
  logic [13:0]     cx_q, cx_d, cy_q, cy_d;
  logic [5:0]      angle_q, angle_d;
  logic [RW-1:0]   rot_cnt_q, rot_cnt_d;
  logic            hit_q, hit_d;
  logic [1:0]      try_q, try_d;

  logic            cos_neg, sin_neg, fwd_only, back_only, x_sub, y_sub;
  logic signed [15:0] step_x, step_y, sum_x, sum_y;
  logic [13:0]     cand_x, cand_y;

  // Negative results clamp to 0, overshoot clamps to the screen edge.
  function automatic logic [13:0] clamp(input logic signed [15:0] v,
                                        input logic [13:0] maxv);
    if (v < 0)                          return 14'd0;
    else if (v > $signed({2'b00, maxv})) return maxv;
    else                                 return v[13:0];
  endfunction

  always_comb begin
    cos_neg   = (angle_q >= 6'd12) && (angle_q <= 6'd33);
    sin_neg   = (angle_q >= 6'd23);
    fwd_only  = fwd & ~back;
    back_only = back & ~fwd;
    step_x    = $signed({8'd0, cos} << SPEED_SHIFT);
    step_y    = $signed({8'd0, sin} << SPEED_SHIFT);
    // X moves by +dir*scos*step; reversing the drive flips the sign.
    x_sub     = back_only ^ cos_neg;
    // Y moves by -dir*ssin*step (screen Y grows downward).
    y_sub     = (back_only == sin_neg);
    sum_x     = $signed({2'b00, x_q}) + (x_sub ? -step_x : step_x);
    sum_y     = $signed({2'b00, y_q}) + (y_sub ? -step_y : step_y);
  end

  // Candidate presented to the wall checker and committed on a clear ack.
  always_comb begin
    cand_x = cx_q;
    cand_y = cy_q;
`ifdef TANK_MOTION_SLIDE_EN
    case (try_q)
      2'd0:    begin cand_x = cx_q; cand_y = cy_q; end
      2'd1:    begin cand_x = cx_q; cand_y = y_q;  end
      default: begin cand_x = x_q;  cand_y = cy_q; end
    endcase
`endif
  end

  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    y_d       = y_q;
    cx_d      = cx_q;
    cy_d      = cy_q;
    angle_d   = angle_q;
    rot_cnt_d = rot_cnt_q;
    hit_d     = hit_q;
    try_d     = try_q;
    case (state_q)
      S_IDLE: if (frame_tick) state_d = S_ROT;
      S_ROT: begin
        if (rot_left ^ rot_right) begin
          if (rot_cnt_q == ROT_LAST) begin
            rot_cnt_d = '0;
            if (rot_left) angle_d = (angle_q == ANGLE_TOP) ? 6'd0 : angle_q + 6'd1;
            else          angle_d = (angle_q == 6'd0) ? ANGLE_TOP : angle_q - 6'd1;
          end else begin
            rot_cnt_d = rot_cnt_q + RW'(1);
          end
        end else begin
          rot_cnt_d = '0;
        end
        // Extra cycle lets the lookup settle on the new heading.
        state_d = S_CALC;
      end
      S_CALC: begin
        if (fwd_only | back_only) begin
          cx_d    = clamp(sum_x, X_MAX_FP);
          cy_d    = clamp(sum_y, Y_MAX_FP);
          try_d   = 2'd0;
          state_d = S_REQ;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_REQ: begin
        if (wall_ack) begin
          hit_d   = wall_hit;
          state_d = S_COMMIT;
        end
      end
      S_COMMIT: begin
        state_d = S_IDLE;
        if (!hit_q) begin
          x_d = cand_x;
          y_d = cand_y;
        end
`ifdef TANK_MOTION_SLIDE_EN
        else if (try_q != 2'd2) begin
          try_d   = try_q + 2'd1;
          state_d = S_REQ;
        end
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q   <= S_IDLE;
      x_q       <= 14'(INIT_X << 4);
      y_q       <= 14'(INIT_Y << 4);
      cx_q      <= 14'(INIT_X << 4);
      cy_q      <= 14'(INIT_Y << 4);
      angle_q   <= 6'(INIT_ANGLE);
      rot_cnt_q <= '0;
      hit_q     <= 1'b0;
      try_q     <= 2'd0;
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      y_q       <= y_d;
      cx_q      <= cx_d;
      cy_q      <= cy_d;
      angle_q   <= angle_d;
      rot_cnt_q <= rot_cnt_d;
      hit_q     <= hit_d;
      try_q     <= try_d;
    end
  end

  assign AngleI   = angle_q;
  assign PosX     = x_q[13:4];
  assign PosY     = y_q[13:4];
  assign wall_req = (state_q == S_REQ);
  assign wall_x   = cand_x[13:4];
  assign wall_y   = cand_y[13:4];
  assign busy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_tank_motion.sv
module tb_tank_motion;
  logic       Clk = 1'b0;
  logic       Reset, frame_tick, rot_left, rot_right, fwd, back;
  logic [7:0] sin, cos;
  logic [5:0] AngleI;
  logic [9:0] PosX, PosY, wall_x, wall_y;
  logic       wall_req, wall_ack, wall_hit, busy;

  int ncmp = 0;
  int nerr = 0;

  tank_motion #(.ROT_DIV(1)) dut (
    .Clk(Clk), .Reset(Reset), .frame_tick(frame_tick),
    .rot_left(rot_left), .rot_right(rot_right), .fwd(fwd), .back(back),
    .sin(sin), .cos(cos), .AngleI(AngleI), .PosX(PosX), .PosY(PosY),
    .wall_req(wall_req), .wall_x(wall_x), .wall_y(wall_y),
    .wall_ack(wall_ack), .wall_hit(wall_hit), .busy(busy)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input int obs, input int exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge Clk); #1;
  endtask

  task automatic pulse_tick();
    frame_tick = 1'b1; cyc(); frame_tick = 1'b0;
  endtask

  task automatic wait_req(input string tag);
    int n = 0;
    while (!wall_req && n < 20) begin cyc(); n++; end
    check({tag, "_req_seen"}, int'(wall_req), 1);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 20) begin cyc(); n++; end
    if (busy) check({tag, "_idle_timeout"}, int'(busy), 0);
  endtask

  task automatic ack(input logic hit);
    wall_ack = 1'b1; wall_hit = hit; cyc();
    wall_ack = 1'b0; wall_hit = 1'b0;
  endtask

  // Full moving frame with a single clear/blocked acknowledge.
  task automatic move_frame(input logic hit);
    pulse_tick();
    wait_req("move");
    ack(hit);
    wait_idle("move");
  endtask

  // Frame with no drive key: no handshake expected.
  task automatic still_frame();
    pulse_tick();
    wait_idle("still");
  endtask

  initial begin
    int n;
    Reset = 1'b1; frame_tick = 0; rot_left = 0; rot_right = 0; fwd = 0; back = 0;
    sin = 8'd0; cos = 8'd16; wall_ack = 0; wall_hit = 0;
    cyc(); cyc(); Reset = 1'b0;

    check("rst_posx", PosX, 320);
    check("rst_posy", PosY, 240);
    check("rst_angle", AngleI, 0);
    check("rst_req", wall_req, 0);
    check("rst_busy", busy, 0);

    // Heading 0, cos=1.0 forward: one sixteenth of 16 -> +1 pixel in X.
    fwd = 1;
    pulse_tick();
    wait_req("f0");
    check("f0_wall_x", wall_x, 321);
    check("f0_wall_y", wall_y, 240);
    ack(1'b0);
    wait_idle("f0");
    check("f0_posx", PosX, 321);
    check("f0_posy", PosY, 240);

    // Rotation wrap both ways, and both keys cancelling.
    fwd = 0; rot_right = 1; still_frame();
    check("rot_right_wrap", AngleI, 44);
    rot_right = 0; rot_left = 1; still_frame();
    check("rot_left_wrap", AngleI, 0);
    rot_right = 1; still_frame();
    check("rot_both", AngleI, 0);
    rot_left = 0; rot_right = 0;

    // Blocked move: candidate (322,239) rejected.
    fwd = 1; sin = 8'd16;
    pulse_tick();
    wait_req("hit");
    check("hit_wall_x", wall_x, 322);
    check("hit_wall_y", wall_y, 239);
    ack(1'b1);
`ifdef TANK_MOTION_SLIDE_EN
    wait_req("slide");
    check("slide_wall_x", wall_x, 322);
    check("slide_wall_y", wall_y, 240);
    ack(1'b0);
    wait_idle("slide");
    check("slide_posx", PosX, 322);
    check("slide_posy", PosY, 240);
`else
    wait_idle("hit");
    check("hit_posx", PosX, 321);
    check("hit_posy", PosY, 240);
`endif

    // Back to INIT, turn to heading 23 (cos and sin both negative).
    Reset = 1; cyc(); Reset = 0;
    fwd = 0; rot_left = 1;
    for (int i = 0; i < 23; i++) still_frame();
    rot_left = 0;
    check("angle23", AngleI, 23);
    fwd = 1; cos = 8'd16; sin = 8'd1;
    for (int i = 0; i < 16; i++) move_frame(1'b0);
    check("a23_posx", PosX, 304);
    check("a23_posy", PosY, 241);

    // Heading 22 (cos negative): drive into the left edge.
    fwd = 0; rot_right = 1; still_frame(); rot_right = 0;
    check("angle22", AngleI, 22);
    fwd = 1; sin = 8'd0;
    n = 0;
    while (PosX != 0 && n < 400) begin move_frame(1'b0); n++; end
    check("left_edge_posx", PosX, 0);
    check("left_edge_frames", n, 304);

    // One more frame at the edge, with a stray tick while waiting for ack.
    pulse_tick();
    wait_req("edge");
    check("edge_wall_x", wall_x, 0);
    check("edge_wall_y", wall_y, 241);
    pulse_tick();
    check("edge_req_held", wall_req, 1);
    ack(1'b0);
    wait_idle("edge");
    check("edge_posx", PosX, 0);
    for (int i = 0; i < 5; i++) cyc();
    check("stray_tick_dropped", busy, 0);

    // Reset while a request is outstanding.
    pulse_tick();
    wait_req("rreq");
    Reset = 1; cyc();
    check("rreq_req_drop", wall_req, 0);
    check("rreq_busy", busy, 0);
    Reset = 0; cyc();
    check("rreq_posx", PosX, 320);
    check("rreq_posy", PosY, 240);
    check("rreq_angle", AngleI, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
